// File: rtl/grf_wport_arb.sv
// Register-file write-port arbiter between pipeline writeback and the MDU, with a
// busy scoreboard for MDU destinations and a starvation guard that forces MDU grants.
module grf_wport_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        hazard_stall,
  output logic        pipe_hold,
  output logic        GRF_WE,
  output logic [4:0]  Wreg,
  output logic [31:0] Wdata
);

  // state  | meaning
  // NORMAL | writeback has priority; refused MDU writes are counted
  // FORCE  | MDU owns the port for one cycle while the pipeline is held
  typedef enum logic {NORMAL, FORCE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic [3:0]  starve;
  logic [3:0]  starve_inc;
  logic [31:0] busy;
  logic [31:0] busy_nxt;
  logic        wb_own;
  logic        refused;
  logic        issue_set;

  always_comb begin
    wb_own       = wb_we && (|wb_reg);
    hazard_stall = !reset && (((|rs) && busy[rs]) || ((|rt) && busy[rt]) ||
                              (issue_valid && (|issue_reg) && busy[issue_reg]));
    mdu_ready    = 1'b0;
    GRF_WE       = 1'b0;
    Wreg         = wb_reg;
    Wdata        = wb_data;
    if (!reset) begin
      if (state == FORCE || !wb_own) begin
        // register 0 is accepted from the MDU but never written
        mdu_ready = mdu_valid;
        GRF_WE    = mdu_valid && (|mdu_reg);
        Wreg      = mdu_reg;
        Wdata     = mdu_data;
      end else begin
        GRF_WE    = 1'b1;
      end
    end
    refused    = mdu_valid && !mdu_ready;
    issue_set  = issue_valid && (|issue_reg) && !hazard_stall;
    starve_inc = starve + 4'd1;
    busy_nxt   = busy;
    if (mdu_valid && mdu_ready) busy_nxt[mdu_reg] = 1'b0;
    if (issue_set)              busy_nxt[issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NORMAL;
      starve    <= 4'd0;
      pipe_hold <= 1'b0;
      busy      <= 32'd0;
    end else begin
      busy <= busy_nxt;
      if (state == FORCE) begin
        state     <= NORMAL;
        starve    <= 4'd0;
        pipe_hold <= 1'b0;
      end else if (refused) begin
        starve <= starve_inc;
        if (starve_inc == LIMIT) begin
          state     <= FORCE;
          pipe_hold <= 1'b1;
        end
      end else begin
        starve <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_grf_wport_arb.sv
// Bench for grf_wport_arb: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the arbitration and scoreboard rules.
module tb_grf_wport_arb;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset, wb_we, mdu_valid, issue_valid;
  logic [4:0]  wb_reg, mdu_reg, issue_reg, rs, rt;
  logic [31:0] wb_data, mdu_data;
  logic        mdu_ready, hazard_stall, pipe_hold, GRF_WE;
  logic [4:0]  Wreg;
  logic [31:0] Wdata;

  grf_wport_arb #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .rs(rs), .rt(rt),
    .hazard_stall(hazard_stall), .pipe_hold(pipe_hold),
    .GRF_WE(GRF_WE), .Wreg(Wreg), .Wdata(Wdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  bit          m_busy [32];
  int          m_starve;
  bit          m_force;
  bit          e_ready, e_we, e_hz;
  logic [4:0]  e_reg;
  logic [31:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_out();
    e_hz = !reset && ((rs != 0 && m_busy[rs]) || (rt != 0 && m_busy[rt]) ||
                      (issue_valid && issue_reg != 0 && m_busy[issue_reg]));
    e_ready = 0; e_we = 0; e_reg = 0; e_data = 0;
    if (!reset) begin
      if (!m_force && wb_we && wb_reg != 0) begin
        e_we = 1; e_reg = wb_reg; e_data = wb_data;
      end else if (mdu_valid) begin
        e_ready = 1; e_we = (mdu_reg != 0); e_reg = mdu_reg; e_data = mdu_data;
      end
    end
  endtask

  task automatic check_all();
    model_out();
    chk("hazard_stall", hazard_stall, e_hz);
    chk("mdu_ready", mdu_ready, e_ready);
    chk("grf_we", GRF_WE, e_we);
    chk("pipe_hold", pipe_hold, m_force);
    if (e_we) begin
      chk("wreg", Wreg, e_reg);
      chk("wdata", Wdata, e_data);
    end
  endtask

  task automatic model_clk();
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_starve = 0;
      m_force  = 0;
    end else begin
      if (e_ready && mdu_reg != 0) m_busy[mdu_reg] = 0;
      if (issue_valid && issue_reg != 0 && !e_hz) m_busy[issue_reg] = 1;
      if (m_force) begin
        m_force = 0; m_starve = 0;
      end else if (mdu_valid && !e_ready) begin
        m_starve++;
        if (m_starve >= LIM) m_force = 1;
      end else begin
        m_starve = 0;
      end
    end
  endtask

  task automatic idle();
    reset = 0; wb_we = 0; wb_reg = 0; wb_data = 0;
    mdu_valid = 0; mdu_reg = 0; mdu_data = 0;
    issue_valid = 0; issue_reg = 0; rs = 0; rt = 0;
  endtask

  task automatic finish_cyc();
    @(posedge clk);
    model_clk();
  endtask

  task automatic start_starve();
    for (int c = 0; c < LIM; c++) begin
      @(negedge clk);
      idle(); wb_we = 1; wb_reg = 8; wb_data = 32'hAA00 + c;
      mdu_valid = 1; mdu_reg = 3; mdu_data = 32'hBEEF;
      #1 check_all();
      chk("starve_refused", mdu_ready, 0);
      finish_cyc();
    end
  endtask

  bit mdu_pend;

  initial begin
    foreach (m_busy[i]) m_busy[i] = 0;
    m_starve = 0; m_force = 0;

    @(negedge clk); idle(); reset = 1;
    #1 chk("rst_we", GRF_WE, 0);
    chk("rst_ready", mdu_ready, 0);
    finish_cyc();
    @(negedge clk); idle(); reset = 1; mdu_valid = 1; mdu_reg = 4; wb_we = 1; wb_reg = 2;
    #1 check_all();
    finish_cyc();

    // writeback alone owns the port
    @(negedge clk); idle(); wb_we = 1; wb_reg = 8; wb_data = 32'h1234;
    #1 check_all();
    chk("wb_we", GRF_WE, 1); chk("wb_reg", Wreg, 8); chk("wb_data", Wdata, 32'h1234);
    chk("wb_ready", mdu_ready, 0);
    finish_cyc();

    // busy set by issue, cleared by MDU write
    @(negedge clk); idle(); issue_valid = 1; issue_reg = 5;
    #1 check_all(); finish_cyc();
    @(negedge clk); idle(); rs = 5; mdu_valid = 1; mdu_reg = 5; mdu_data = 32'h55;
    #1 check_all(); chk("haz_set", hazard_stall, 1); chk("haz_mdu_acc", mdu_ready, 1);
    finish_cyc();
    @(negedge clk); idle(); rs = 5;
    #1 check_all(); chk("haz_clr", hazard_stall, 0);
    finish_cyc();

    // writes aimed at register 0
    @(negedge clk); idle(); wb_we = 1; wb_reg = 0; mdu_valid = 1; mdu_reg = 9; mdu_data = 32'h99;
    #1 check_all(); chk("r0_ready", mdu_ready, 1); chk("r0_wreg", Wreg, 9); chk("r0_we", GRF_WE, 1);
    finish_cyc();
    @(negedge clk); idle(); wb_we = 1; wb_reg = 0;
    #1 check_all(); chk("r0_wb_we", GRF_WE, 0);
    finish_cyc();
    @(negedge clk); idle(); mdu_valid = 1; mdu_reg = 0;
    #1 check_all(); chk("r0_mdu_ready", mdu_ready, 1); chk("r0_mdu_we", GRF_WE, 0);
    finish_cyc();

    // issue and clear of the same register: set wins
    @(negedge clk); idle(); issue_valid = 1; issue_reg = 7; mdu_valid = 1; mdu_reg = 7;
    #1 check_all(); finish_cyc();
    @(negedge clk); idle(); rt = 7;
    #1 check_all(); chk("set_wins", hazard_stall, 1);
    finish_cyc();

    // starvation then forced grant
    start_starve();
    @(negedge clk); idle(); wb_we = 1; wb_reg = 8; mdu_valid = 1; mdu_reg = 3; mdu_data = 32'hBEEF;
    #1 check_all();
    chk("force_hold", pipe_hold, 1); chk("force_ready", mdu_ready, 1);
    chk("force_wreg", Wreg, 3); chk("force_wdata", Wdata, 32'hBEEF);
    finish_cyc();
    @(negedge clk); idle(); wb_we = 1; wb_reg = 8;
    #1 check_all(); chk("force_end_hold", pipe_hold, 0); chk("force_end_wreg", Wreg, 8);
    finish_cyc();

    // reset landing in the forced cycle (busy[7] is still set from above)
    start_starve();
    @(negedge clk); idle(); reset = 1; mdu_valid = 1; mdu_reg = 3; rt = 7;
    #1 check_all();
    chk("rstf_we", GRF_WE, 0); chk("rstf_ready", mdu_ready, 0); chk("rstf_haz", hazard_stall, 0);
    finish_cyc();
    @(negedge clk); idle(); rt = 7; mdu_valid = 1; mdu_reg = 3; wb_we = 1; wb_reg = 8;
    #1 check_all();
    chk("rstf_hold", pipe_hold, 0); chk("rstf_busy", hazard_stall, 0); chk("rstf_normal", mdu_ready, 0);
    finish_cyc();

    // randomized traffic with MDU requests held until accepted
    mdu_pend = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 99) == 0);
      wb_we       = ($urandom_range(0, 9) < 7);
      wb_reg      = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      if (!mdu_pend) begin
        mdu_valid = ($urandom_range(0, 1) == 1);
        mdu_reg   = 5'($urandom_range(0, 7));
        mdu_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_reg   = 5'($urandom_range(0, 7));
      rs          = 5'($urandom_range(0, 7));
      rt          = 5'($urandom_range(0, 7));
      #1 check_all();
      mdu_pend = mdu_valid && !e_ready && !reset;
      finish_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
